md_div_unit: RTL and testbench

- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage beside the ALU. It consumes forwarded operands and funct3 from the ID/EX register outputs, and its result feeds the EX->intermediate pipeline register.
- Drives a stall request to the hazard unit so IF/ID/EX freeze while a division is in flight.

---
 rtl/rv_m_pkg.sv | 16 +
 rtl/div_step.sv | 22 ++
 rtl/md_div_unit.sv | 160 ++++++++++++++++
 tb/tb_md_div_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_m_pkg.sv
// Shared RV32M definitions: divider state encoding and
// the M-extension funct3 codes used by multiplier, divider and decoder.
package rv_m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] sh;
    logic [XLEN:0] diff;

    // Extra top bit makes the sign of the trial subtraction explicit.
    assign sh    = {rem_i, quo_i[XLEN-1]};
    assign diff  = sh - {1'b0, dvs_i};
    assign rem_o = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/md_div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU in the EX stage.
// Stalls IF/ID/EX while a division is in flight.
module md_div_unit
    import rv_m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            stall
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             rsel_q, rsel_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [4:0]       rd_q, rd_d;

    logic            signed_op;
    logic            rem_op;
    logic            req;
    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div0, ovf;
    logic [XLEN-1:0] step_rem, step_quo;

    always_comb begin
        signed_op = 1'b0;
        rem_op    = 1'b0;
        case (funct3)
            F3_DIV:  signed_op = 1'b1;
            F3_DIVU: signed_op = 1'b0;
            F3_REM:  begin signed_op = 1'b1; rem_op = 1'b1; end
            F3_REMU: rem_op = 1'b1;
            default: ;
        endcase
    end

    assign req   = start & funct3[2];
    assign sa    = signed_op & op_a[XLEN-1];
    assign sb    = signed_op & op_b[XLEN-1];
    assign mag_a = sa ? -op_a : op_a;
    assign mag_b = sb ? -op_b : op_b;
    assign div0  = (op_b == '0);
    assign ovf   = signed_op & (op_a == MIN_NEG) & (op_b == '1);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        rsel_d  = rsel_q;
        res_d   = res_q;
        rd_d    = rd_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        rd_d   = rd_in;
                        rsel_d = rem_op;
                        if (div0) begin
                            res_d   = rem_op ? op_a : '1;
                            state_d = DONE;
                        end else if (ovf) begin
                            res_d   = rem_op ? '0 : MIN_NEG;
                            state_d = DONE;
                        end else begin
                            quo_d   = mag_a;
                            dvs_d   = mag_b;
                            rem_d   = '0;
                            cnt_d   = '0;
                            qsign_d = sa ^ sb;
                            rsign_d = sa;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        if (rsel_q)
                            res_d = rsign_q ? -step_rem : step_rem;
                        else
                            res_d = qsign_q ? -step_quo : step_quo;
                        state_d = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            rsel_q  <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            rsel_q  <= rsel_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign stall  = ((state_q == IDLE) & req) | (state_q == CALC);
    assign result = res_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_md_div_unit.sv
// Self-checking bench for md_div_unit: directed plan cases plus
// randomized operations against an arithmetic reference model.
module tb_md_div_unit;
    import rv_m_pkg::*;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        clr, flush, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, stall;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_chk = 0;
    int n_fail = 0;

    md_div_unit dut (
        .clk    (clk),
        .clr    (clr),
        .flush  (flush),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic ovf;
        ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        case (f3)
            F3_DIVU: return a / b;
            F3_REMU: return a % b;
            F3_DIV:  return ovf ? MIN_NEG : 32'($signed(a) / $signed(b));
            default: return ovf ? 32'h0 : 32'($signed(a) % $signed(b));
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int nstall);
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        #1 nstall = stall ? 1 : 0;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (stall) nstall++;
            @(posedge clk);
            #1 lat++;
        end
        res = result;
        rdo = rd_out;
        check("stall_at_done", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1 check("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res,
                         input int exp_lat);
        logic [31:0] res;
        logic [4:0]  rdo;
        int lat, ns;
        run_op(f3, a, b, rd, res, rdo, lat, ns);
        check({tag, "_res"}, res, exp_res);
        check({tag, "_rd"}, {27'b0, rdo}, {27'b0, rd});
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, prev, a, b;
        logic [4:0]  rdo, rd;
        logic [2:0]  f3;
        int lat, ns, ndone, r;

        clr = 1'b1; flush = 1'b0; start = 1'b0;
        funct3 = 3'b000; op_a = '0; op_b = '0; rd_in = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk) clr = 1'b0;

        run_op(F3_DIVU, 32'd100, 32'd7, 5'd5, res, rdo, lat, ns);
        check("divu_res", res, 32'd14);
        check("divu_rd", {27'b0, rdo}, 32'd5);
        check("divu_lat", lat, 33);
        check("divu_stall", ns, 33);

        do_op("remu", F3_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33);
        do_op("div_neg", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
        do_op("rem_neg", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
        do_op("rem_negb", F3_REM, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33);
        do_op("divu_z", F3_DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
        do_op("remu_z", F3_REMU, 32'd5, 32'd0, 5'd11, 32'd5, 1);
        do_op("div_ovf", F3_DIV, MIN_NEG, 32'hFFFF_FFFF, 5'd12, MIN_NEG, 1);
        do_op("rem_ovf", F3_REM, MIN_NEG, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);

        // second start while busy must be ignored
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd4;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1 if (done) ndone++;
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_res", result, 32'd14);
        check("busy_start_rd", {27'b0, rd_out}, 32'd3);

        // flush at iteration 10
        prev = result;
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_res", result, prev);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) ndone++;
        end
        check("flush_ndone", ndone, 0);
        do_op("after_flush", F3_DIV, 32'd20, 32'd4, 5'd2, 32'd5, 33);

        // asynchronous clear mid-calculation
        @(negedge clk);
        start = 1'b1; funct3 = F3_REMU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_busy", {31'b0, busy}, 32'd0);
        check("clr_stall", {31'b0, stall}, 32'd0);
        check("clr_res", result, 32'd0);
        check("clr_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk) clr = 1'b0;
        do_op("after_clr", F3_REMU, 32'd17, 32'd5, 5'd14, 32'd2, 33);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom_range(0, 31));
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'($urandom_range(1, 15));
            else if (r == 3) a = 32'($urandom_range(0, 255));
            else if (r == 4) b = -32'($urandom_range(1, 15));
            run_op(f3, a, b, rd, res, rdo, lat, ns);
            check("rnd_res", res, model(f3, a, b));
            check("rnd_rd", {27'b0, rdo}, {27'b0, rd});
            check("rnd_lat", lat,
                  (b == 0 || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF)) ? 1 : 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
